// File: rtl/botoes_pkg.sv
// Shared definitions for the button front-end: channel state encoding,
// default timing constants and the command-id width helper.
package botoes_pkg;

  typedef enum logic [1:0] {
    SOLTO        = 2'd0,
    FILTRA_PRESS = 2'd1,
    PRESSIONADO  = 2'd2,
    FILTRA_SOLTA = 2'd3
  } estado_t;

  localparam int DEBOUNCE_CYC_DEF = 16;
  localparam int LONG_CYC_DEF     = 1000;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/filtro_canal.sv
// One button channel: 2-FF synchroniser, debounce FSM and, with LONG_PRESS_EN,
// a saturating hold counter that defers the press event to the release.
module filtro_canal
  import botoes_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
`ifdef LONG_PRESS_EN
  , parameter int LONG_CYC = LONG_CYC_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic b_raw,
  output logic press,
  output logic held,
  output logic long_press
);

  localparam logic [7:0] LIMITE = 8'(DEBOUNCE_CYC);

  logic       sync1_reg;
  logic       s_reg;
  estado_t    estado_reg;
  logic [7:0] cnt_reg;
  logic       press_reg;
  logic       held_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      s_reg     <= 1'b1;
    end else begin
      sync1_reg <= b_raw;
      s_reg     <= sync1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_reg <= SOLTO;
      cnt_reg    <= 8'd0;
      press_reg  <= 1'b0;
      held_reg   <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      case (estado_reg)
        SOLTO: begin
          if (!s_reg) begin
            estado_reg <= FILTRA_PRESS;
            cnt_reg    <= 8'd1;
          end
        end
        FILTRA_PRESS: begin
          if (s_reg) begin
            estado_reg <= SOLTO;
            cnt_reg    <= 8'd0;
          end else if (cnt_reg == LIMITE) begin
            estado_reg <= PRESSIONADO;
            cnt_reg    <= 8'd0;
            held_reg   <= 1'b1;
`ifndef LONG_PRESS_EN
            press_reg  <= 1'b1;
`endif
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        PRESSIONADO: begin
          if (s_reg) begin
            estado_reg <= FILTRA_SOLTA;
            cnt_reg    <= 8'd1;
          end
        end
        FILTRA_SOLTA: begin
          if (!s_reg) begin
            estado_reg <= PRESSIONADO;
            cnt_reg    <= 8'd0;
          end else if (cnt_reg == LIMITE) begin
            estado_reg <= SOLTO;
            cnt_reg    <= 8'd0;
            held_reg   <= 1'b0;
`ifdef LONG_PRESS_EN
            press_reg  <= 1'b1;
`endif
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: begin
          estado_reg <= SOLTO;
          cnt_reg    <= 8'd0;
        end
      endcase
    end
  end

  assign press = press_reg;
  assign held  = held_reg;

`ifdef LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);

  logic [HOLD_W-1:0] hold_reg;

  // Hold keeps its value through release so it is still valid when the event fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg <= '0;
    end else if (estado_reg == FILTRA_PRESS) begin
      hold_reg <= '0;
    end else if (estado_reg == PRESSIONADO && hold_reg != HOLD_MAX) begin
      hold_reg <= hold_reg + 1'b1;
    end
  end

  assign long_press = press_reg && (hold_reg >= HOLD_MAX);
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/escalonador_botoes.sv
// Button front-end top: per-channel filters, one-deep pending queue per button
// and a round-robin valid/ready command port. Optional feature: LONG_PRESS_EN.
module escalonador_botoes
  import botoes_pkg::*;
#(
  parameter int N_BOTOES     = 3,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int LONG_CYC     = LONG_CYC_DEF,
  localparam int ID_W        = id_width(N_BOTOES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BOTOES-1:0] b_in,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [ID_W-1:0]     cmd_id,
  output logic                cmd_long,
  output logic [N_BOTOES-1:0] btn_estado,
  output logic                perdido
);

  logic [N_BOTOES-1:0] press;
  logic [N_BOTOES-1:0] long_flag;
  logic [N_BOTOES-1:0] clr;
  logic [N_BOTOES-1:0] pending_reg, pending_next;
  logic [N_BOTOES-1:0] long_pend_reg, long_pend_next;
  logic [ID_W-1:0]     ptr_reg;
  logic [ID_W-1:0]     cmd_id_reg;
  logic [ID_W-1:0]     grant_id;
  logic                grant_found;
  logic                cmd_valid_reg;
  logic                cmd_long_reg;
  logic                perdido_reg;
  logic                drop;
  logic                accept;

  assign accept = cmd_valid_reg & cmd_ready;

  generate
    for (genvar gi = 0; gi < N_BOTOES; gi++) begin : g_canal
      filtro_canal #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
`ifdef LONG_PRESS_EN
        , .LONG_CYC(LONG_CYC)
`endif
      ) u_filtro (
        .clk       (clk),
        .rst       (rst),
        .b_raw     (b_in[gi]),
        .press     (press[gi]),
        .held      (btn_estado[gi]),
        .long_press(long_flag[gi])
      );
      assign clr[gi] = accept && (cmd_id_reg == ID_W'(gi));
    end
  endgenerate

  // A press landing on the cycle its own channel is accepted re-queues, not drops.
  always_comb begin
    pending_next   = pending_reg & ~clr;
    long_pend_next = long_pend_reg;
    drop           = 1'b0;
    for (int i = 0; i < N_BOTOES; i++) begin
      if (press[i]) begin
        if (pending_next[i]) begin
          drop = 1'b1;
        end else begin
          pending_next[i]   = 1'b1;
          long_pend_next[i] = long_flag[i];
        end
      end
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < N_BOTOES; k++) begin
      if (!grant_found && pending_reg[(int'(ptr_reg) + k) % N_BOTOES]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(ptr_reg) + k) % N_BOTOES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg   <= '0;
      long_pend_reg <= '0;
      ptr_reg       <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_id_reg    <= '0;
      cmd_long_reg  <= 1'b0;
      perdido_reg   <= 1'b0;
    end else begin
      pending_reg   <= pending_next;
      long_pend_reg <= long_pend_next;
      perdido_reg   <= drop;
      if (accept) begin
        cmd_valid_reg <= 1'b0;
        ptr_reg       <= (cmd_id_reg == ID_W'(N_BOTOES - 1)) ? '0 : cmd_id_reg + 1'b1;
      end else if (!cmd_valid_reg && grant_found) begin
        cmd_valid_reg <= 1'b1;
        cmd_id_reg    <= grant_id;
        cmd_long_reg  <= long_pend_reg[grant_id];
      end
    end
  end

  assign cmd_valid = cmd_valid_reg;
  assign cmd_id    = cmd_id_reg;
  assign cmd_long  = cmd_long_reg;
  assign perdido   = perdido_reg;

endmodule

// File: tb/tb_escalonador_botoes.sv
// Directed bench for escalonador_botoes: reset, clean press, bounce rejection,
// round-robin order, backpressure/drop, mid-handshake reset, long presses.
module tb_escalonador_botoes;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] b_in;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_id;
  logic       cmd_long;
  logic [2:0] btn_estado;
  logic       perdido;

  int total = 0;
  int bad   = 0;
  int perdido_count = 0;
  int   hs_ids[$];
  logic hs_long[$];

  always #5 clk = ~clk;

  escalonador_botoes #(
    .N_BOTOES    (3),
    .DEBOUNCE_CYC(16),
    .LONG_CYC    (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .b_in      (b_in),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_id    (cmd_id),
    .cmd_long  (cmd_long),
    .btn_estado(btn_estado),
    .perdido   (perdido)
  );

  // Inputs change just after posedge, so the negedge view equals what the next edge samples.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        hs_ids.push_back(int'(cmd_id));
        hs_long.push_back(cmd_long);
        $display("handshake: id=%0d long=%0b t=%0t", cmd_id, cmd_long, $time);
      end
      if (perdido) perdido_count++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int id_at(input int idx);
    return (idx < hs_ids.size()) ? hs_ids[idx] : -1;
  endfunction

  function automatic int long_at(input int idx);
    return (idx < hs_long.size()) ? int'(hs_long[idx]) : -1;
  endfunction

  initial begin
    rst = 1'b1;
    b_in = 3'b111;
    cmd_ready = 1'b0;
    step(2);
    chk("reset_valid", int'(cmd_valid), 0);
    chk("reset_id", int'(cmd_id), 0);
    chk("reset_long", int'(cmd_long), 0);
    chk("reset_estado", int'(btn_estado), 0);
    chk("reset_perdido", int'(perdido), 0);
    rst = 1'b0;
    step(2);

`ifndef LONG_PRESS_EN
    // Clean press on button 1: valid exactly at edge 20.
    cmd_ready = 1'b1;
    hs_ids.delete();
    b_in = 3'b101;
    step(20);
    chk("clean_valid_edge19", int'(cmd_valid), 0);
    chk("clean_estado_held", int'(btn_estado), 2);
    step(1);
    chk("clean_valid_edge20", int'(cmd_valid), 1);
    chk("clean_id", int'(cmd_id), 1);
    step(1);
    chk("clean_valid_dropped", int'(cmd_valid), 0);
    step(18);
    b_in = 3'b111;
    step(30);
    chk("clean_cmd_count", hs_ids.size(), 1);
    chk("clean_cmd_id", id_at(0), 1);
    chk("clean_estado_released", int'(btn_estado), 0);

    // Bounce on button 0: 5-cycle pulses never pass the filter.
    hs_ids.delete();
    perdido_count = 0;
    for (int i = 0; i < 6; i++) begin
      b_in = 3'b110;
      step(5);
      b_in = 3'b111;
      step(5);
    end
    step(30);
    chk("bounce_cmd_count", hs_ids.size(), 0);
    chk("bounce_perdido", perdido_count, 0);
    chk("bounce_estado", int'(btn_estado), 0);

    // Round-robin from pointer 0.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    cmd_ready = 1'b1;
    hs_ids.delete();
    b_in = 3'b000;
    step(40);
    b_in = 3'b111;
    step(30);
    chk("rr3_count", hs_ids.size(), 3);
    chk("rr3_first", id_at(0), 0);
    chk("rr3_second", id_at(1), 1);
    chk("rr3_third", id_at(2), 2);
    hs_ids.delete();
    b_in = 3'b010;
    step(40);
    b_in = 3'b111;
    step(30);
    chk("rr2_count", hs_ids.size(), 2);
    chk("rr2_first", id_at(0), 0);
    chk("rr2_second", id_at(1), 2);

    // Backpressure: second press of button 2 is dropped.
    cmd_ready = 1'b0;
    hs_ids.delete();
    perdido_count = 0;
    b_in = 3'b011;
    step(25);
    chk("bp_valid_1", int'(cmd_valid), 1);
    chk("bp_id_1", int'(cmd_id), 2);
    b_in = 3'b111;
    step(25);
    chk("bp_valid_2", int'(cmd_valid), 1);
    chk("bp_id_2", int'(cmd_id), 2);
    chk("bp_no_drop_yet", perdido_count, 0);
    b_in = 3'b011;
    step(25);
    chk("bp_perdido", perdido_count, 1);
    chk("bp_id_3", int'(cmd_id), 2);
    b_in = 3'b111;
    step(30);
    cmd_ready = 1'b1;
    step(1);
    chk("bp_valid_after_accept", int'(cmd_valid), 0);
    step(10);
    chk("bp_cmd_count", hs_ids.size(), 1);
    chk("bp_cmd_id", id_at(0), 2);
    chk("bp_perdido_final", perdido_count, 1);
    chk("bp_valid_idle", int'(cmd_valid), 0);

    // Reset while a command is presented.
    cmd_ready = 1'b0;
    hs_ids.delete();
    b_in = 3'b110;
    step(25);
    chk("rst_mid_valid_before", int'(cmd_valid), 1);
    chk("rst_mid_id_before", int'(cmd_id), 0);
    rst = 1'b1;
    b_in = 3'b111;
    step(1);
    chk("rst_mid_valid", int'(cmd_valid), 0);
    chk("rst_mid_id", int'(cmd_id), 0);
    chk("rst_mid_long", int'(cmd_long), 0);
    chk("rst_mid_estado", int'(btn_estado), 0);
    chk("rst_mid_perdido", int'(perdido), 0);
    rst = 1'b0;
    cmd_ready = 1'b1;
    step(40);
    chk("rst_mid_no_cmd", hs_ids.size(), 0);
    chk("rst_mid_valid_after", int'(cmd_valid), 0);
`else
    // Long press (hold well past LONG_CYC=100) and short press.
    cmd_ready = 1'b1;
    hs_ids.delete();
    hs_long.delete();
    b_in = 3'b101;
    step(150);
    chk("long_no_cmd_while_held", hs_ids.size(), 0);
    b_in = 3'b111;
    step(40);
    chk("long_count", hs_ids.size(), 1);
    chk("long_id", id_at(0), 1);
    chk("long_flag", long_at(0), 1);
    hs_ids.delete();
    hs_long.delete();
    b_in = 3'b101;
    step(50);
    b_in = 3'b111;
    step(40);
    chk("short_count", hs_ids.size(), 1);
    chk("short_id", id_at(0), 1);
    chk("short_flag", long_at(0), 0);
    chk("long_idle_valid", int'(cmd_valid), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/escalonador_botoes.md
Name: escalonador_botoes

Overview:
- Front-end controller for all player buttons: synchronises, debounces and edge-detects N raw active-low buttons.
- Queues one pending press per button.
- Serialises presses to the game FSM over a valid/ready command port, using round-robin arbitration.
- Sits between the board pins and the main game state machine; the game FSM consumes one command per handshake.

Parameters:
- N_BOTOES, 3, number of button channels (2..8)
- DEBOUNCE_CYC, 16, consecutive stable samples required to accept a press or release (2..255)
- LONG_CYC, 1000, hold duration in cycles that marks a press as long (used only with LONG_PRESS_EN)
- ID_W, $clog2(N_BOTOES), width of cmd_id (derived localparam, not overridable)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- b_in  in  N_BOTOES  raw button pins, active-low (0 = pressed)
- cmd_valid  out  1  a command is presented
- cmd_ready  in  1  game FSM accepts the command this cycle
- cmd_id  out  ID_W  index of the button the command refers to
- cmd_long  out  1  command is a long press (constant 0 without LONG_PRESS_EN)
- btn_estado  out  N_BOTOES  debounced level per button, 1 = held
- perdido  out  1  one-cycle pulse: a press was dropped because that channel was already pending

Behaviour:
- Reset, effective on the clk edge with rst=1:
  - All outputs 0.
  - Every channel in SOLTO with counter 0.
  - Synchroniser flops loaded with 1 (released).
  - Pending bits 0; round-robin pointer 0.
  - Asserting rst mid-handshake drops the presented command; no partial state survives.
- Synchroniser: 2-FF per b_in bit. All logic below uses the synchronised value s.
- Per-channel FSM, with an 8-bit counter:
  - SOLTO: s=0 -> FILTRA_PRESS, counter=1.
  - FILTRA_PRESS: s=1 -> SOLTO, counter=0. Else counter++; when counter reaches DEBOUNCE_CYC -> PRESSIONADO, emitting a 1-cycle press event.
  - PRESSIONADO: btn_estado=1. s=1 -> FILTRA_SOLTA, counter=1.
  - FILTRA_SOLTA: s=0 -> PRESSIONADO. Else counter++; at DEBOUNCE_CYC -> SOLTO.
  - Exactly one press event per physical press. Bounces shorter than DEBOUNCE_CYC produce none.
- Pending bits:
  - A press event sets pending[i] on the next edge.
  - An event arriving while pending[i]=1 (and not being accepted in the same cycle) is dropped and perdido pulses.
  - If the event coincides with acceptance of channel i, pending[i] stays 1 (new press queued) and perdido stays 0.
- Arbiter/output register:
  - When cmd_valid=0 and any pending bit is set, grant the first set bit at or after the pointer, wrapping modulo N_BOTOES.
  - cmd_valid=1 and cmd_id (and cmd_long) are registered next cycle.
  - cmd_id and cmd_long are held stable while cmd_valid=1 and cmd_ready=0.
  - On cmd_valid & cmd_ready: clear pending[cmd_id], set pointer = cmd_id+1 (wrap), drop cmd_valid.
  - No back-to-back commands: at most one command per 2 cycles.
  - cmd_ready while cmd_valid=0 is ignored.
- Latency: raw fall at sampling edge 0 -> press event at edge 2+DEBOUNCE_CYC -> pending at +1 -> cmd_valid at +2, i.e. edge DEBOUNCE_CYC+4, if the port is idle.

Optional Feature:
- Macro LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter runs in PRESSIONADO and saturates at LONG_CYC.
  - The press event is deferred to release (exit of FILTRA_SOLTA to SOLTO); the queued command carries cmd_long = (hold >= LONG_CYC).
  - A per-channel long bit is stored alongside pending.
- Undefined:
  - Events fire on press acceptance as above.
  - cmd_long tied to 0; no hold counters synthesised.

Decomposition:
- Package botoes_pkg: channel state encoding (SOLTO, FILTRA_PRESS, PRESSIONADO, FILTRA_SOLTA), default DEBOUNCE_CYC/LONG_CYC constants, function computing ID_W.
- One sub-module, filtro_canal: synchroniser + per-channel FSM + optional hold counter. Outputs press event, btn_estado bit and long flag.
- Generated N_BOTOES times. Arbiter and pending register stay in the top module.

Test Plan:
- Clean press: b_in[1] low for 40 cycles, cmd_ready=1 -> cmd_valid at edge 20 (DEBOUNCE_CYC=16), cmd_id=1, exactly one command; btn_estado[1]=1 while held.
- Bounce: b_in[0] toggled every 5 cycles for 60 cycles then released -> no command, perdido never pulses.
- Round-robin: all 3 buttons press simultaneously, cmd_ready=1 -> commands in id order 0,1,2. Then press 0 and 2 together -> order 0 stays after pointer rule; pointer=0 so 0 then 2.
- Backpressure/drop: cmd_ready=0, press button 2 twice (release in between) -> cmd_id=2 held stable, second press pulses perdido. Raise cmd_ready -> single command.
- Reset mid-op: rst=1 for 1 cycle while cmd_valid=1 -> next cycle all outputs 0, pending cleared, no command reappears.
- LONG_PRESS_EN, LONG_CYC=100: hold 150 cycles -> after release one command with cmd_long=1. Hold 50 cycles -> cmd_long=0.
